// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory boot controller.
// Holds the controller state encoding and the memory geometry constants.
package imem_pkg;

  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 32;
  localparam int MAX_WORDS   = 16;
  localparam int WORD_STRIDE = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot loader and fetch-ownership controller for the instruction memory.
// Ports: clk/rst_n, ld_* valid/ready load stream, halt_req/reload_req,
// cpu_pc fetch address, cpu_rst_n core reset, mem_* memory port,
// state_o/words_loaded/err status.
module imem_boot_ctrl #(
  parameter int ADDR_W    = imem_pkg::ADDR_W,
  parameter int DATA_W    = imem_pkg::DATA_W,
  parameter int MAX_WORDS = imem_pkg::MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              halt_req,
  input  logic              reload_req,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_rst_n,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        state_o,
  output logic [4:0]        words_loaded,
  output logic              err
);

  import imem_pkg::*;

  localparam logic [ADDR_W-1:0] STRIDE =
    ADDR_W'(WORD_STRIDE);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'((MAX_WORDS - 1) * WORD_STRIDE);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] addrReg;
  logic              drain;
  logic              drainErr;
  logic              accept;

  assign accept  = ld_valid & ld_ready;
  assign state_o = state;

  // Fetch path bypasses the register so RUN stays single-cycle.
  assign mem_addr = (state == RUN) ? cpu_pc : addrReg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LOAD;
      wptr         <= '0;
      addrReg      <= '0;
      words_loaded <= '0;
      ld_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      cpu_rst_n    <= 1'b0;
      err          <= 1'b0;
      drain        <= 1'b0;
      drainErr     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          // drain: the final write is on the port this cycle
          if (drain) begin
            drain <= 1'b0;
            if (drainErr) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              state     <= RUN;
              cpu_rst_n <= 1'b1;
            end
          end else if (accept) begin
            mem_we       <= 1'b1;
            addrReg      <= wptr;
            mem_wdata    <= ld_data;
            wptr         <= wptr + STRIDE;
            words_loaded <= words_loaded + 5'd1;
            if (ld_last || wptr == LAST_ADDR) begin
              drain    <= 1'b1;
              drainErr <= !ld_last;
              ld_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          // Track the PC so HALT/ERROR hold the last fetch address.
          addrReg <= cpu_pc;
          if (cpu_pc[1:0] != 2'b00) begin
            state     <= ERROR;
            err       <= 1'b1;
            cpu_rst_n <= 1'b0;
          end else if (halt_req) begin
            state     <= HALT;
            cpu_rst_n <= 1'b0;
          end
        end
        HALT, ERROR: begin
          if (reload_req) begin
            state        <= LOAD;
            wptr         <= '0;
            words_loaded <= '0;
            ld_ready     <= 1'b1;
            err          <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl.
// Directed test-plan steps plus randomized programs against a word-list model.
module tb_imem_boot_ctrl;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        halt_req = 1'b0;
  logic        reload_req = 1'b0;
  logic [5:0]  cpu_pc = '0;
  logic        cpu_rst_n;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  state_o;
  logic [4:0]  words_loaded;
  logic        err;

  int passCnt = 0;
  int totalCnt = 0;
  int wrCnt = 0;
  logic [31:0] progWords [16];

  imem_boot_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .halt_req(halt_req),
    .reload_req(reload_req),
    .cpu_pc(cpu_pc),
    .cpu_rst_n(cpu_rst_n),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .state_o(state_o),
    .words_loaded(words_loaded),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) wrCnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: word k of a program lands at byte address 4*k, one write per accept.
  task automatic loadWords(input int n, input bit lastOnFinal,
                           input bit gaps);
    int k;
    k = 0;
    while (k < n) begin
      ld_data  = progWords[k];
      ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ld_last  = lastOnFinal && (k == n - 1);
      chk("ld_ready_in_load", ld_ready, 1);
      step();
      if (ld_valid) begin
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 64'(4 * k));
        chk("wr_data", mem_wdata, progWords[k]);
        chk("wr_count", words_loaded, 64'(k + 1));
        k++;
      end else begin
        chk("idle_we", mem_we, 0);
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic expectRun();
    chk("drain_ready", ld_ready, 0);
    chk("drain_cpu_rst", cpu_rst_n, 0);
    step();
    chk("run_state", state_o, RUN);
    chk("run_cpu_rst", cpu_rst_n, 1);
    chk("run_err", err, 0);
    chk("run_ready", ld_ready, 0);
  endtask

  task automatic haltAndReload();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_state", state_o, HALT);
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    chk("reload_state", state_o, LOAD);
    chk("reload_words", words_loaded, 0);
  endtask

  initial begin
    int w0;
    int n;
    logic [5:0] lastPc;

    // reset values
    step();
    step();
    chk("rst_state", state_o, LOAD);
    chk("rst_ready", ld_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst_n, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    rst_n = 1'b1;

    // 3-word program, back to back
    progWords[0] = 32'h20020005;
    progWords[1] = 32'h2003000c;
    progWords[2] = 32'h2067fff7;
    w0 = wrCnt;
    loadWords(3, 1'b1, 1'b0);
    chk("p3_words", words_loaded, 3);
    expectRun();
    chk("p3_wrcnt", wrCnt - w0, 3);
    cpu_pc = 6'd8;
    #1;
    chk("p3_fetch_addr", mem_addr, 8);

    // loader traffic in RUN is ignored
    ld_valid = 1'b1;
    step();
    chk("run_ign_we", mem_we, 0);
    chk("run_ign_state", state_o, RUN);
    ld_valid = 1'b0;

    // misaligned PC
    cpu_pc = 6'h06;
    step();
    chk("mis_state", state_o, ERROR);
    chk("mis_err", err, 1);
    chk("mis_cpu_rst", cpu_rst_n, 0);
    chk("mis_addr_hold", mem_addr, 6);
    cpu_pc = 6'd0;
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    chk("mis_rl_state", state_o, LOAD);
    chk("mis_rl_err", err, 0);
    chk("mis_rl_ready", ld_ready, 1);

    // valid toggled 1,0,1 with last on second beat
    w0 = wrCnt;
    progWords[0] = 32'h11111111;
    progWords[1] = 32'h22222222;
    ld_valid = 1'b1;
    ld_data  = progWords[0];
    step();
    chk("tg_addr0", mem_addr, 0);
    chk("tg_data0", mem_wdata, progWords[0]);
    ld_valid = 1'b0;
    ld_data  = 32'hdeadbeef;
    step();
    chk("tg_gap_we", mem_we, 0);
    ld_valid = 1'b1;
    ld_last  = 1'b1;
    ld_data  = progWords[1];
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("tg_addr1", mem_addr, 4);
    chk("tg_data1", mem_wdata, progWords[1]);
    expectRun();
    chk("tg_wrcnt", wrCnt - w0, 2);

    // halt and reload together in RUN
    halt_req   = 1'b1;
    reload_req = 1'b1;
    step();
    halt_req   = 1'b0;
    reload_req = 1'b0;
    chk("hr_state", state_o, HALT);
    chk("hr_cpu_rst", cpu_rst_n, 0);
    step();
    chk("hr_still_halt", state_o, HALT);
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    chk("hr_rl_state", state_o, LOAD);
    chk("hr_rl_words", words_loaded, 0);

    // 17 words without last: overflow after 16
    for (int i = 0; i < 16; i++) progWords[i] = $urandom;
    w0 = wrCnt;
    loadWords(16, 1'b0, 1'b0);
    chk("ov_last_addr", mem_addr, 60);
    ld_valid = 1'b1;
    ld_data  = 32'hcafef00d;
    chk("ov_ready", ld_ready, 0);
    step();
    chk("ov_state", state_o, ERROR);
    chk("ov_err", err, 1);
    chk("ov_cpu_rst", cpu_rst_n, 0);
    chk("ov_we", mem_we, 0);
    step();
    ld_valid = 1'b0;
    chk("ov_wrcnt", wrCnt - w0, 16);
    chk("ov_err_sticky", err, 1);
    reload_req = 1'b1;
    step();
    reload_req = 1'b0;
    chk("ov_rl_state", state_o, LOAD);
    chk("ov_rl_err", err, 0);
    progWords[0] = 32'h0badc0de;
    loadWords(1, 1'b1, 1'b0);
    expectRun();
    haltAndReload();

    // randomized programs with gaps, fetches and halts
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++) progWords[i] = $urandom;
      w0 = wrCnt;
      loadWords(n, 1'b1, 1'b1);
      expectRun();
      chk("rnd_wrcnt", wrCnt - w0, 64'(n));
      chk("rnd_words", words_loaded, 64'(n));
      lastPc = '0;
      for (int c = 0; c < 4; c++) begin
        lastPc   = {4'($urandom_range(0, 15)), 2'b00};
        cpu_pc   = lastPc;
        ld_valid = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_fetch", mem_addr, lastPc);
        step();
        chk("rnd_run_we", mem_we, 0);
      end
      ld_valid = 1'b0;
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      cpu_pc   = 6'd0;
      #1;
      chk("rnd_halt_state", state_o, HALT);
      chk("rnd_halt_hold", mem_addr, lastPc);
      reload_req = 1'b1;
      step();
      reload_req = 1'b0;
      chk("rnd_rl_state", state_o, LOAD);
    end

    // reset in the write cycle cancels the write
    ld_valid = 1'b1;
    ld_data  = 32'h12345678;
    step();
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_we", mem_we, 0);
    chk("mr_state", state_o, LOAD);
    chk("mr_words", words_loaded, 0);
    chk("mr_ready", ld_ready, 1);
    chk("mr_addr", mem_addr, 0);
    chk("mr_wdata", mem_wdata, 0);
    chk("mr_err", err, 0);
    progWords[0] = 32'h00000013;
    loadWords(1, 1'b1, 1'b0);
    expectRun();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load and fetch-ownership controller for the single-cycle processor's 64-entry instruction memory. After reset it accepts a stream of 32-bit instruction words on a valid/ready load port and writes them into instruction memory at byte addresses 0, 4, 8, …. It then releases the processor and hands the memory address port to the CPU program counter. It also supports halt, reload and error handling, so the core never fetches from a partially written program.

## Interface

Parameters:
- ADDR_W, 6, instruction-memory address width; memory index equals byte address
- DATA_W, 32, instruction width
- MAX_WORDS, 16, program capacity in words (addresses 0..60, stride 4)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- ld_valid  in  1  loader has a word
- ld_ready  out  1  controller accepts a word this cycle
- ld_data  in  DATA_W  instruction word
- ld_last  in  1  marks the final word of the program
- halt_req  in  1  request to stop the CPU (sampled in RUN)
- reload_req  in  1  request a new load (sampled in HALT or ERROR)
- cpu_pc  in  ADDR_W  CPU fetch address
- cpu_rst_n  out  1  active-low reset to the processor core
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ADDR_W  instruction-memory address
- mem_wdata  out  DATA_W  instruction-memory write data
- state_o  out  2  current state encoding
- words_loaded  out  5  count of words written in the last load
- err  out  1  sticky error flag

## Operation

- State encoding: LOAD=0, RUN=1, HALT=2, ERROR=3.
- Values on reset: state LOAD, wptr=0, words_loaded=0, ld_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, err=0.
- **LOAD**
  - ld_ready=1, except in the cycle after accepting ld_last.
  - An accept (ld_valid & ld_ready) registers mem_we=1, mem_addr=wptr, mem_wdata=ld_data. It then advances wptr by 4 and increments words_loaded.
  - Accepting ld_last takes the state to RUN after the write cycle.
  - An accept at wptr=60 without ld_last is an overflow: the word is still written, then state goes to ERROR and err=1.
  - cpu_rst_n=0 throughout LOAD.
- **RUN**
  - cpu_rst_n=1, ld_ready=0, mem_we=0.
  - mem_addr=cpu_pc combinationally, so the fetch path stays single-cycle.
  - cpu_pc[1:0]≠0 means misalignment: next state ERROR, err=1.
  - halt_req=1 moves to HALT. Misalignment takes priority over halt_req.
- **HALT**
  - cpu_rst_n=0, mem_we=0, mem_addr holds the last cpu_pc.
  - reload_req moves to LOAD with wptr=0 and words_loaded=0.
- **ERROR**
  - Same outputs as HALT; err stays 1.
  - reload_req moves to LOAD and clears err.
- ld_valid outside LOAD is ignored; no word is consumed.
- ld_data must be held until accepted; the controller never drops a beat.

## Timing

- Write latency: a word accepted in cycle N is written (mem_we=1) in cycle N+1.
- Back-to-back accepts give one write per cycle.
- ld_last accepted in N: write in N+1, ld_ready=0 in N+1, RUN and cpu_rst_n=1 from N+2.
- halt_req high in cycle N (RUN): cpu_rst_n=0 from N+1.
- reload_req high in cycle N (HALT/ERROR): LOAD with ld_ready=1 from N+1.
- rst_n low at any edge, including mid-load: the reset values above apply from the next cycle. A pending registered write is cancelled (mem_we=0).
- Simultaneous halt_req and reload_req in RUN: halt only; reload_req is ignored until HALT.

## Structure

- Shared package imem_pkg: state enum (LOAD/RUN/HALT/ERROR), ADDR_W, DATA_W, MAX_WORDS, WORD_STRIDE=4.
- Single module; no sub-module required.
- The address mux (registered load address vs. cpu_pc) lives at the output. It may be split into imem_addr_mux if the memory gains a second port.

## Test plan

- **Reset then load 3 words** (0x20020005, 0x2003000c, 0x2067fff7, last on third):
  - writes at addresses 0, 4, 8 in consecutive cycles
  - words_loaded=3
  - cpu_rst_n rises 2 cycles after the last accept
  - in RUN, mem_addr follows cpu_pc=8
- **ld_valid toggled 1,0,1 with ld_last on the second beat:** exactly 2 writes, at addresses 0 and 4, with no duplicate or lost word.
- **17 words without ld_last:**
  - 16 writes, the last at 60
  - then ERROR, err=1, cpu_rst_n stays 0
  - reload_req clears err and returns to LOAD with wptr=0
- **In RUN, cpu_pc=0x06:** ERROR next cycle, err=1, cpu_rst_n=0.
- **In RUN, halt_req and reload_req both high:**
  - state HALT only
  - a further reload_req gives LOAD with words_loaded=0
- **rst_n low in the cycle after an accept:**
  - mem_we=0 next cycle
  - state LOAD, wptr=0, all reset values restored
